// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the multiplexed-display scan sequencer: state
// encoding, digit count, index width and the slot counter width.
// ---------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int CNT_W      = 16;

endpackage

// File: rtl/slot_counter.sv
// ---------------------------------------------------------------------------
// slot_counter
// Loadable down-counter used to time both the dwell (ACTIVE) and blank
// slots. It stops at zero, and tc_o flags that zero.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset, clears the count
//   load_i     load load_val_i on this edge, otherwise count down
//   load_val_i value loaded on load_i
//   tc_o       terminal count, high while the count is zero
// ---------------------------------------------------------------------------
module slot_counter
    import scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: state is updated with non-blocking assignments inside a single
    // async-reset always_ff, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
// Steps a 2-bit digit index through 0..3 for a downstream 2-to-4 decoder.
// Each digit gets DWELL_CYCLES lit cycles followed by BLANK_CYCLES of dead
// time. The per-digit mask bit is sampled once on slot entry. All outputs
// come straight from registers.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         1 = scan, 0 = idle (aborts the current slot)
//   mask[3:0]   per-digit light enable
//   a, b        decoder select, index[1] and index[0]
//   en          decoder enable, high only while a digit is lit
//   frame_start one-cycle pulse on the first lit cycle of digit 0
// ---------------------------------------------------------------------------
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic                  a,
    output logic                  b,
    output logic                  en,
    output logic                  frame_start
);

    // The counter holds "cycles remaining minus one", so a slot of N cycles
    // loads N-1 and ends on the edge where tc is seen.
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD =
        (BLANK_CYCLES == 0) ? '0 : CNT_W'(BLANK_CYCLES - 1);
    // With no blanking, a finished dwell slot reloads straight into the next one.
    localparam logic [CNT_W-1:0] AFTER_DWELL_LOAD =
        (BLANK_CYCLES == 0) ? DWELL_LOAD : BLANK_LOAD;

    state_e           state_q;
    logic [IDX_W-1:0] index_q;
    logic             en_q;
    logic             frame_start_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_tc;
    logic [IDX_W-1:0] index_next;

    assign index_next = index_q + 1'b1;  // natural 2-bit wrap 3 -> 0

    // Counter control: reload on every slot boundary and on any drop to
    // idle (loading 0 clears it); count down otherwise.
    always_comb begin
        cnt_load = 1'b1;
        cnt_val  = '0;
        if (run) begin
            unique case (state_q)
                IDLE:    cnt_val = DWELL_LOAD;
                ACTIVE:  if (cnt_tc) cnt_val = AFTER_DWELL_LOAD;
                         else        cnt_load = 1'b0;
                BLANK:   if (cnt_tc) cnt_val = DWELL_LOAD;
                         else        cnt_load = 1'b0;
                default: cnt_val = '0;
            endcase
        end
    end

    slot_counter u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tc_o       (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            index_q       <= '0;
            en_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (!run) begin
            state_q       <= IDLE;
            index_q       <= '0;
            en_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q       <= ACTIVE;
                    index_q       <= '0;
                    en_q          <= mask[0];
                    frame_start_q <= 1'b1;
                end
                ACTIVE: begin
                    if (cnt_tc) begin
                        if (BLANK_CYCLES == 0) begin
                            index_q       <= index_next;
                            en_q          <= mask[index_next];
                            frame_start_q <= (index_next == '0);
                        end else begin
                            state_q <= BLANK;
                            en_q    <= 1'b0;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_tc) begin
                        state_q       <= ACTIVE;
                        index_q       <= index_next;
                        en_q          <= mask[index_next];
                        frame_start_q <= (index_next == '0);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    index_q <= '0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign a           = index_q[1];
    assign b           = index_q[0];
    assign en          = en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
// Two sequencers share the stimulus: DWELL=3/BLANK=1 and DWELL=3/BLANK=0.
// The reference model tracks elapsed cycles since the scan started and
// derives index, lit phase and frame pulse arithmetically from the slot
// and frame periods.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

    localparam int DWELL = 3;
    localparam int P0    = 4;  // DWELL + BLANK for dut0
    localparam int P1    = 3;  // DWELL + 0     for dut1

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       run   = 1'b0;
    logic [3:0] mask  = 4'b0000;

    logic a0, b0, en0, fs0;
    logic a1, b1, en1, fs1;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .a(a0), .b(b0), .en(en0), .frame_start(fs0)
    );

    scan_sequencer #(.DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .mask(mask),
        .a(a1), .b(b1), .en(en1), .frame_start(fs1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic running = 1'b0;
    int   t       = 0;      // cycles since the scan started (0 = first lit cycle)
    logic slot_en0 = 1'b0;
    logic slot_en1 = 1'b0;

    function automatic int next_t();
        return running ? t + 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else if (!run) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            t       <= next_t();
            if (next_t() % P0 == 0) slot_en0 <= mask[(next_t() / P0) % 4];
            if (next_t() % P1 == 0) slot_en1 <= mask[(next_t() / P1) % 4];
        end
    end

    function automatic int exp_idx(input int p);
        return running ? (t / p) % 4 : 0;
    endfunction

    function automatic int exp_en(input int p, input logic se);
        return (running && (t % p) < DWELL && se) ? 1 : 0;
    endfunction

    function automatic int exp_fs(input int p);
        return (running && (t % (4 * p)) == 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            check("idx0", int'({a0, b0}), exp_idx(P0));
            check("en0",  int'(en0),      exp_en(P0, slot_en0));
            check("fs0",  int'(fs0),      exp_fs(P0));
            check("idx1", int'({a1, b1}), exp_idx(P1));
            check("en1",  int'(en1),      exp_en(P1, slot_en1));
            check("fs1",  int'(fs1),      exp_fs(P1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and confirm outputs drop before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_idx0", int'({a0, b0}), 0);
        check("async_en0",  int'(en0),      0);
        check("async_fs0",  int'(fs0),      0);
        check("async_idx1", int'({a1, b1}), 0);
        check("async_en1",  int'(en1),      0);
        check("async_fs1",  int'(fs1),      0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        cycles(2);
        rst_n    = 1'b1;
        checking = 1'b1;
        check("rst_idx0", int'({a0, b0}), 0);
        check("rst_en0",  int'(en0),      0);
        check("rst_fs0",  int'(fs0),      0);
        cycles(3);                         // idle with run low

        mask = 4'b1111; run = 1'b1; cycles(40);
        mask = 4'b0101;             cycles(40);
        mask = 4'b0000;             cycles(24);

        // Mask drops in the 2nd cycle of a digit-0 slot.
        run = 1'b0;                 cycles(1);
        mask = 4'b1111; run = 1'b1; cycles(2);
        mask = 4'b0000;             cycles(20);

        // run dropped in the 2nd cycle of digit 2 (dut0), then restarted.
        run = 1'b0;                 cycles(1);
        mask = 4'b1111; run = 1'b1; cycles(10);
        run = 1'b0;                 cycles(3);
        run = 1'b1;                 cycles(20);

        // Asynchronous reset during a lit slot, then resume.
        cycles(1);
        mid_reset();
        cycles(10);

        for (int i = 0; i < 600; i++) begin
            mask = 4'($urandom);
            run  = ($urandom_range(0, 39) != 0);
            cycles(1);
            if (i % 150 == 75) mid_reset();
        end

        run = 1'b1; mask = 4'b1010; cycles(30);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
